// File: rtl/pulse_meter.sv
// Measures the high time and period of one selected pulse lane in clk cycles,
// returning one result per accepted start; overflow flags a saturated, incomplete measurement.
module pulse_meter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       pulse_in,
  input  logic [2:0]       ch_sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_sync1, r_sync2;
  logic             r_dly;
  logic [2:0]       r_lane;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [2:0]       w_lane;
  logic             w_sync, w_rise, w_fall, w_sat, w_accept;

  assign w_accept = (r_state == S_IDLE) && start;
  // While idle the delay register tracks ch_sel, so the first ARM cycle
  // compares two samples of the newly selected lane and never sees a false rise.
  assign w_lane   = (r_state == S_IDLE) ? ch_sel : r_lane;
  assign w_sync   = r_sync2[w_lane];
  assign w_rise   = w_sync & ~r_dly;
  assign w_fall   = ~w_sync & r_dly;
  assign w_sat    = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_ONE;
    w_high_nxt   = r_high;
    w_period_nxt = r_period;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (start) begin
          w_state_nxt = S_ARM;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end else if (w_sat) begin
          w_state_nxt  = S_IDLE;
          w_high_nxt   = CNT_MAX;
          w_period_nxt = CNT_MAX;
          w_ovf_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_fall) begin
          w_state_nxt = S_LOW;
          w_high_nxt  = r_cnt;
        end else if (w_sat) begin
          w_state_nxt  = S_IDLE;
          w_high_nxt   = CNT_MAX;
          w_period_nxt = CNT_MAX;
          w_ovf_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
        end
      end
      S_LOW: begin
        // An edge in the saturating cycle still completes the measurement.
        if (w_rise) begin
          w_state_nxt  = S_IDLE;
          w_period_nxt = r_cnt;
          w_done_nxt   = 1'b1;
        end else if (w_sat) begin
          w_state_nxt  = S_IDLE;
          w_period_nxt = CNT_MAX;
          w_ovf_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_dly    <= 1'b0;
      r_lane   <= '0;
      r_cnt    <= '0;
      r_high   <= '0;
      r_period <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync1  <= pulse_in;
      r_sync2  <= r_sync1;
      r_dly    <= w_sync;
      if (w_accept) begin
        r_lane <= ch_sel;
      end
      r_cnt    <= w_cnt_nxt;
      r_high   <= w_high_nxt;
      r_period <= w_period_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign high_cnt   = r_high;
  assign period_cnt = r_period;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: planned per-lane waveforms, a waveform-level result
// predictor and a per-cycle comparison of busy/done/results against it.
module tb_pulse_meter;
  localparam int W    = 8;
  localparam int MAXV = 255;
  localparam int N    = 8192;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   pulse_in;
  logic [2:0]   ch_sel = '0;
  logic         start = 1'b0;
  logic         busy, done, overflow;
  logic [W-1:0] high_cnt, period_cnt;

  pulse_meter #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ch_sel(ch_sel), .start(start),
    .busy(busy), .done(done), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .overflow(overflow)
  );

  always #10 clk = ~clk;

  // cyc counts rising edges; the pin value sampled on edge k is wave[lane][k].
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         wave [8][N];
  logic [7:0] drv_sync = '0;
  logic       async_mode = 1'b0;
  logic       async_bit = 1'b0;

  always @(negedge clk) begin
    for (int l = 0; l < 8; l++) drv_sync[l] = wave[l][cyc % N];
  end
  assign pulse_in = async_mode ? (8'(async_bit) << 5) : drv_sync;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model state: expected completion cycle and the results to be held afterwards.
  bit model_on = 1'b1;
  bit m_active = 1'b0;
  int m_done_cyc = 0;
  int e_h = 0, e_p = 0;
  bit e_ov = 1'b0;
  int l_h = 0, l_p = 0;
  bit l_ov = 1'b0;
  int last_done_cyc = 0;

  // A measurement starting on edge s looks at pin samples from s-1 on (two-cycle
  // detect latency); it times out when the counter would pass MAXV.
  function automatic void predict(input int s, input int ln, output int d,
                                  output int h, output int p, output bit ov);
    int r, f, r2;
    r = -1; f = -1; r2 = -1;
    for (int k = s - 1; k <= s + MAXV - 1; k++)
      if (r < 0 && wave[ln][k] && !wave[ln][k-1]) r = k;
    ov = 1'b1; h = MAXV; p = MAXV;
    if (r < 0) begin
      d = s + MAXV + 1;
      return;
    end
    for (int k = r + 1; k <= r + MAXV; k++)
      if (f < 0 && !wave[ln][k] && wave[ln][k-1]) f = k;
    d = r + MAXV + 2;
    if (f < 0) return;
    h = f - r;
    for (int k = f + 1; k <= r + MAXV; k++)
      if (r2 < 0 && wave[ln][k] && !wave[ln][k-1]) r2 = k;
    if (r2 < 0) return;
    p  = r2 - r;
    ov = 1'b0;
    d  = r2 + 2;
  endfunction

  function automatic void set_const(input int ln, input int from, input int to, input bit v);
    for (int k = from; k < to; k++) wave[ln][k] = v;
  endfunction

  function automatic void set_per(input int ln, input int from, input int to,
                                  input int hi, input int lo, input int ph);
    for (int k = from; k < to; k++) wave[ln][k] = (((k - from + ph) % (hi + lo)) < hi);
  endfunction

  always @(negedge clk) begin : cmp
    bit eb, ed;
    if (done) last_done_cyc = cyc;
    if (model_on) begin
      eb = m_active && (cyc < m_done_cyc);
      ed = m_active && (cyc == m_done_cyc);
      if (ed) begin
        l_h = e_h; l_p = e_p; l_ov = e_ov;
        m_active = 1'b0;
      end
      chk("busy", int'(busy), int'(eb));
      chk("done", int'(done), int'(ed));
      chk("overflow", int'(overflow), eb ? 0 : int'(l_ov));
      if (!eb) begin
        chk("high_cnt", int'(high_cnt), l_h);
        chk("period_cnt", int'(period_cnt), l_p);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_start(input int ln);
    int d, h, p;
    bit ov;
    start  = 1'b1;
    ch_sel = 3'(ln);
    if (model_on && !m_active && !reset) begin
      predict(cyc, ln, d, h, p, ov);
      e_h = h; e_p = p; e_ov = ov;
      m_done_cyc = d + 1;
      m_active = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  // noisy: wiggle ch_sel and fire ignored starts while the measurement runs.
  task automatic wait_idle(input string name, input int bound, input bit noisy);
    int n = 0;
    while (m_active && n < bound) begin
      if (noisy) begin
        ch_sel = 3'($urandom);
        start  = ($urandom_range(0, 3) == 0);
      end
      tick();
      start = 1'b0;
      n++;
    end
    if (m_active) begin
      checks++;
      errors++;
      $display("FAIL %s: no completion within %0d cycles", name, bound);
    end
  endtask

  initial begin
    int n, s, ln, hi, lo;

    repeat (4) tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset high", int'(high_cnt), 0);
    chk("reset period", int'(period_cnt), 0);
    chk("reset ovf", int'(overflow), 0);
    reset = 1'b0;
    repeat (4) tick();

    // Basic: lane 3 5 high / 15 low, other lanes toggling randomly.
    n = cyc;
    for (int l = 0; l < 8; l++)
      for (int k = n + 1; k < n + 200; k++) wave[l][k] = 1'($urandom_range(0, 1));
    set_const(3, n + 1, n + 4, 1'b0);
    set_per(3, n + 4, n + 200, 5, 15, 0);
    repeat (3) tick();
    issue_start(3);
    wait_idle("basic", 100, 1'b0);
    chk("basic high", int'(high_cnt), 5);
    chk("basic period", int'(period_cnt), 20);
    chk("basic ovf", int'(overflow), 0);
    chk("basic busy", int'(busy), 0);

    // Lane isolation sweep: lane k has period 8+2k at 50% duty.
    n = cyc;
    for (int k = 0; k < 8; k++) begin
      set_const(k, n + 1, n + 4, 1'b0);
      set_per(k, n + 4, n + 600, 4 + k, 4 + k, 0);
    end
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      issue_start(k);
      wait_idle("lane", 100, 1'b0);
      chk($sformatf("lane%0d high", k), int'(high_cnt), 4 + k);
      chk($sformatf("lane%0d period", k), int'(period_cnt), 8 + 2 * k);
    end

    // Lane high at start is skipped; start while busy is ignored.
    n = cyc;
    s = n + 3;
    set_const(2, n + 1, s + 7, 1'b1);
    set_const(2, s + 7, s + 13, 1'b0);
    set_per(2, s + 13, s + 200, 4, 6, 0);
    set_per(6, n + 1, n + 200, 2, 3, 0);
    repeat (3) tick();
    issue_start(2);
    repeat (3) tick();
    issue_start(6);
    wait_idle("fresh", 100, 1'b0);
    chk("fresh high", int'(high_cnt), 4);
    chk("fresh period", int'(period_cnt), 10);

    // Saturation with the lane stuck low.
    n = cyc;
    set_const(1, n + 1, n + 400, 1'b0);
    repeat (2) tick();
    s = cyc;
    issue_start(1);
    wait_idle("sat low", 400, 1'b0);
    chk_rng("sat latency", last_done_cyc - 1 - s, 254, 256);
    chk("sat ovf", int'(overflow), 1);
    chk("sat high", int'(high_cnt), 255);
    chk("sat period", int'(period_cnt), 255);

    // Saturation after one 3-cycle high.
    n = cyc;
    set_const(1, n + 1, n + 4, 1'b0);
    set_const(1, n + 4, n + 7, 1'b1);
    set_const(1, n + 7, n + 400, 1'b0);
    repeat (3) tick();
    issue_start(1);
    wait_idle("sat high", 400, 1'b0);
    chk("sat2 ovf", int'(overflow), 1);
    chk("sat2 high", int'(high_cnt), 3);
    chk("sat2 period", int'(period_cnt), 255);

    // Reset in the middle of a HIGH phase, then a clean measurement.
    n = cyc;
    set_const(4, n + 1, n + 4, 1'b0);
    set_per(4, n + 4, n + 400, 10, 10, 0);
    repeat (3) tick();
    issue_start(4);
    repeat (6) tick();
    chk("pre-reset busy", int'(busy), 1);
    reset = 1'b1;
    m_active = 1'b0;
    l_h = 0; l_p = 0; l_ov = 1'b0;
    tick();
    chk("abort busy", int'(busy), 0);
    chk("abort high", int'(high_cnt), 0);
    chk("abort period", int'(period_cnt), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    issue_start(4);
    wait_idle("post reset", 100, 1'b0);
    chk("post reset high", int'(high_cnt), 10);
    chk("post reset period", int'(period_cnt), 20);

    // Randomized waveforms, with ch_sel noise and ignored starts while busy.
    for (int it = 0; it < 24; it++) begin
      n = cyc;
      for (int l = 0; l < 8; l++) begin
        hi = $urandom_range(1, 12);
        lo = $urandom_range(1, 12);
        set_per(l, n + 1, n + 120, hi, lo, $urandom_range(0, 23));
      end
      ln = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) set_const(ln, n + 1, n + 400, 1'($urandom_range(0, 1)));
      issue_start(ln);
      wait_idle("random", 400, 1'b1);
    end

    // Asynchronous lane 5: 100 ns high / 300 ns low, edges 37 ns off the clock grid.
    model_on = 1'b0;
    tick();
    async_mode = 1'b1;
    repeat (4) tick();
    fork
      begin
        @(posedge clk);
        #17;
        repeat (8) begin
          async_bit = 1'b1;
          #100;
          async_bit = 1'b0;
          #300;
        end
      end
    join_none
    issue_start(5);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL async: no done within 200 cycles");
    end else begin
      chk_rng("async high", int'(high_cnt), 4, 6);
      chk_rng("async period", int'(period_cnt), 19, 21);
      chk("async ovf", int'(overflow), 0);
      chk("async busy", int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measurement block for the far end of the pulse generator's 8-lane `pulse` bus. It measures the high time and period of one selected lane in `clk` cycles and returns one result per `start` request. It is used for on-chip self-check of generated waveforms and for bench loop-back, where it is driven directly by the generator output.

## Interface

Parameters:
- `CNT_W`, default 24: width of the high-time and period counters, in cycles.

Ports:
- `clk`  in  1: system clock, 50 MHz nominal.
- `reset`  in  1: asynchronous, active-high reset.
- `pulse_in`  in  8: pulse lanes. Asynchronous to `clk`; each lane is independent.
- `ch_sel`  in  3: lane index to measure. Sampled only when `start` is accepted.
- `start`  in  1: single-cycle request for one measurement.
- `busy`  out  1: high from the cycle after `start` is accepted until the cycle `done` asserts.
- `done`  out  1: one-cycle strobe; result outputs are valid from this cycle on.
- `high_cnt`  out  CNT_W: measured high time, in cycles.
- `period_cnt`  out  CNT_W: measured period, rising edge to next rising edge, in cycles.
- `overflow`  out  1: the measurement ended on counter saturation and did not complete.

## Operation

- **Input path:**
  - Every lane of `pulse_in` passes through a 2-FF synchronizer.
  - The selected lane then feeds a delay register. rise = sync & ~dly; fall = ~sync & dly.
- **Lane latch:** `ch_sel` is latched into `lane_q` when `start` is accepted. Later changes to `ch_sel` have no effect on the running measurement.
- **FSM states:** IDLE, ARM, HIGH, LOW.
- **IDLE:**
  - `busy`=0.
  - `start`=1 → ARM. In the same transition: clear `cnt`, latch `lane_q`, clear `overflow`.
- **ARM:** waits for the first rise.
  - `cnt` increments each cycle as a timeout counter.
  - On rise → HIGH, with `cnt`<=1.
  - A lane already high at `start` is not counted. The block waits for a fresh rise.
- **HIGH:** `cnt` increments each cycle. On fall: `high_cnt`<=`cnt`, then → LOW with `cnt` incrementing.
- **LOW:** `cnt` increments each cycle. On rise: `period_cnt`<=`cnt`, `done`<=1, then → IDLE.
- **Counting result:** a lane high for H cycles and low for L cycles yields `high_cnt`=H and `period_cnt`=H+L.
- **Saturation:** if `cnt` equals all-ones in ARM, HIGH or LOW and no terminating edge is present that cycle:
  - `overflow`<=1 and `done`<=1, then → IDLE.
  - Any field not measured reads all-ones. From ARM or HIGH, both fields read all-ones. From LOW, `high_cnt` is valid and `period_cnt` reads all-ones.
  - An edge and saturation in the same cycle resolve in favour of the edge.
- **start while busy:** ignored; there is no queueing.
- **Result hold:** `high_cnt`, `period_cnt` and `overflow` hold their values until the next accepted `start`. `overflow` clears on that `start`; the two count fields are overwritten as the new measurement completes.
- **Reset:**
  - Asserting `reset` at any time, including mid-measurement, forces IDLE and clears every register.
  - No `done` is produced for an aborted measurement.

## Timing

- **Reset values:** `busy`=0, `done`=0, `high_cnt`=0, `period_cnt`=0, `overflow`=0. Synchronizers, delay register, `cnt` and `lane_q` are all 0.
- **Start acceptance:** `start` is sampled on the rising edge of `clk` while in IDLE. `busy` rises on the next cycle.
- **Edge latency:** a pin edge reaches the rise/fall detect 2–3 cycles later (synchronizer plus sampling phase). Both edges see identical latency, so measured counts carry ±1 cycle of quantisation for asynchronous inputs and are exact for `clk`-aligned inputs.
- **Completion:**
  - `done` and the updated `period_cnt` appear one cycle after the terminating rise-detect cycle.
  - `busy` drops in the same cycle `done` rises.
  - A new `start` is accepted in the cycle after `done`.
- **Minimum pulse:** the minimum measurable high or low phase is 1 cycle for `clk`-aligned inputs. Input phases shorter than 2 cycles when asynchronous are not guaranteed to be captured.

## Test plan

- **Basic measurement:** `clk`-aligned lane 3 toggles with 5 cycles high, 15 cycles low. `ch_sel`=3, `start` pulsed → `done` once, `high_cnt`=5, `period_cnt`=20, `overflow`=0, `busy` is 0 after `done`.
- **Lane isolation:** lanes 0–7 each carry a different period, 8+2k cycles at 50 % duty. Sweep `ch_sel` 0..7 → `period_cnt`=8+2k and `high_cnt`=4+k for each k.
- **Fresh edge and ignored start:**
  - Lane held high at `start`, falling after 7 cycles, then driven 4 high / 6 low → first result is `high_cnt`=4, `period_cnt`=10.
  - A second `start` issued while `busy` → no effect.
- **Saturation:** `CNT_W`=8, lane stuck low after `start` → `done` 255 cycles after ARM entry (±1), `overflow`=1, both fields =255. Repeat with the lane stuck low after one 3-cycle high → `high_cnt`=3, `period_cnt`=255, `overflow`=1.
- **Reset mid-measurement:**
  - `reset` pulsed while in HIGH → `busy`=0, all outputs 0, no `done`.
  - A subsequent `start` on a 10 high / 10 low lane → `high_cnt`=10, `period_cnt`=20.
- **Asynchronous input:** lane driven with a 37 ns phase offset, high 100 ns / low 300 ns at 20 ns `clk` → `high_cnt` in {4,5,6}, `period_cnt` in {19,20,21}, `overflow`=0.
